// File: rtl/sap_pkg.sv
// Shared definitions for the SAP CPU: control-word bit indices, opcodes and default widths.
// Imported by both the controller and the datapath so the control-word layout has one source.
package sap_pkg;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;
  localparam int CTRL_W     = 12;

  localparam int SIG_HLT       = 11;
  localparam int SIG_PC_INC    = 10;
  localparam int SIG_PC_EN     = 9;
  localparam int SIG_MEM_LOAD  = 8;
  localparam int SIG_MEM_EN    = 7;
  localparam int SIG_IR_LOAD   = 6;
  localparam int SIG_IR_EN     = 5;
  localparam int SIG_A_LOAD    = 4;
  localparam int SIG_A_EN      = 3;
  localparam int SIG_B_LOAD    = 2;
  localparam int SIG_ADDER_SUB = 1;
  localparam int SIG_ADDER_EN  = 0;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_HLT = 4'hF;

  // True when more than one of the bus-driver enables is asserted.
  function automatic logic multi_drive(input logic [4:0] en);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      cnt = cnt + {2'b00, en[i]};
    end
    return (cnt > 3'd1);
  endfunction

endpackage

// File: rtl/sap_ram.sv
// SAP program/data memory: synchronous program-load write port, asynchronous read port.
// A write and a read to the same address in one cycle return the old word on the read port.
module sap_ram
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Program-port write; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sap_datapath.sv
// SAP CPU datapath: PC, MAR, RAM, IR, A/B and adder/subtractor on one shared bus.
// Consumes the controller's control word and returns the current opcode.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] bus,
  output logic              carry,
  output logic              halted,
  output logic              bus_conflict
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic              carry_q, carry_d, halted_q, halted_d, conflict_q, conflict_d;
  logic [DATA_W-1:0] ram_rdata_s, sum_s, bus_s;
  logic              carry_src_s;
  logic [4:0]        drv_en_s;

  sap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (prog_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (mar_q),
    .rdata_o (ram_rdata_s)
  );

  // Adder/subtractor; the extra top bit is carry-out on add and borrow on subtract.
  always_comb begin
    if (ctrl[SIG_ADDER_SUB]) begin
      {carry_src_s, sum_s} = {1'b0, a_q} - {1'b0, b_q};
    end else begin
      {carry_src_s, sum_s} = {1'b0, a_q} + {1'b0, b_q};
    end
  end

  assign drv_en_s = {ctrl[SIG_ADDER_EN], ctrl[SIG_A_EN], ctrl[SIG_IR_EN],
                     ctrl[SIG_MEM_EN], ctrl[SIG_PC_EN]};

  // Priority bus mux: adder, A, IR operand, RAM, PC; idle bus reads 0.
  always_comb begin
    if (ctrl[SIG_ADDER_EN]) begin
      bus_s = sum_s;
    end else if (ctrl[SIG_A_EN]) begin
      bus_s = a_q;
    end else if (ctrl[SIG_IR_EN]) begin
      bus_s = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
    end else if (ctrl[SIG_MEM_EN]) begin
      bus_s = ram_rdata_s;
    end else if (ctrl[SIG_PC_EN]) begin
      bus_s = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    end else begin
      bus_s = {DATA_W{1'b0}};
    end
  end

  // Next-state for all registers; a set halt flag freezes every load and PC increment.
  always_comb begin
    pc_d       = pc_q;
    mar_d      = mar_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    halted_d   = halted_q | ctrl[SIG_HLT];
    conflict_d = conflict_q | multi_drive(drv_en_s);
    if (!halted_q) begin
      if (ctrl[SIG_PC_INC])   pc_d  = pc_q + PC_ONE;        else pc_d  = pc_q;
      if (ctrl[SIG_MEM_LOAD]) mar_d = bus_s[ADDR_W-1:0];    else mar_d = mar_q;
      if (ctrl[SIG_IR_LOAD])  ir_d  = bus_s;                else ir_d  = ir_q;
      if (ctrl[SIG_A_LOAD])   a_d   = bus_s;                else a_d   = a_q;
      if (ctrl[SIG_B_LOAD])   b_d   = bus_s;                else b_d   = b_q;
      if (ctrl[SIG_A_LOAD] && ctrl[SIG_ADDER_EN]) begin
        carry_d = carry_src_s;
      end else begin
        carry_d = carry_q;
      end
    end else begin
      pc_d    = pc_q;
      carry_d = carry_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      mar_q      <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      halted_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      halted_q   <= halted_d;
      conflict_q <= conflict_d;
    end
  end

  assign opcode       = ir_q[7:4];
  assign a_out        = a_q;
  assign bus          = bus_s;
  assign carry        = carry_q;
  assign halted       = halted_q;
  assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench for sap_datapath: directed program table, corner sequences,
// and randomized control words checked against a behavioural register-transfer model.
module tb_sap_datapath;

  logic        clk, rst, prog_we, carry, halted, bus_conflict;
  logic [11:0] ctrl;
  logic [3:0]  prog_addr, opcode;
  logic [7:0]  prog_data, a_out, bus;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] bus_seen;

  sap_datapath dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .opcode(opcode), .a_out(a_out), .bus(bus), .carry(carry),
    .halted(halted), .bus_conflict(bus_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int m_mem[16];
  int m_pc, m_mar, m_ir, m_a, m_b, m_carry, m_halt, m_conf;

  typedef struct {
    logic [11:0] c;
    logic [7:0]  a;
    logic [3:0]  op;
    logic        h;
    logic        cy;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input logic [11:0] c, input logic [7:0] a, input logic [3:0] op,
                         input logic h, input logic cy);
    vec_t v;
    v.c = c; v.a = a; v.op = op; v.h = h; v.cy = cy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
    m_carry = 0; m_halt = 0; m_conf = 0;
  endfunction

  function automatic int model_bus(input logic [11:0] c);
    if (c[0]) return c[1] ? ((m_a - m_b) & 255) : ((m_a + m_b) & 255);
    if (c[3]) return m_a;
    if (c[5]) return m_ir % 16;
    if (c[7]) return m_mem[m_mar];
    if (c[9]) return m_pc;
    return 0;
  endfunction

  function automatic void model_step(input logic [11:0] c, input logic we,
                                     input logic [3:0] wa, input logic [7:0] wd);
    int bv, nen, cy;
    bv  = model_bus(c);
    nen = int'(c[0]) + int'(c[3]) + int'(c[5]) + int'(c[7]) + int'(c[9]);
    cy  = c[1] ? int'(m_a < m_b) : int'(m_a + m_b > 255);
    if (nen > 1) m_conf = 1;
    if (m_halt == 0) begin
      if (c[10]) m_pc = (m_pc + 1) % 16;
      if (c[8])  m_mar = bv % 16;
      if (c[6])  m_ir = bv;
      if (c[4])  m_a = bv;
      if (c[2])  m_b = bv;
      if (c[4] && c[0]) m_carry = cy;
    end
    if (we) m_mem[wa] = wd;
    if (c[11]) m_halt = 1;
  endfunction

  // One clock: drive on falling edge, check bus before the rising edge, registers after it.
  task automatic cyc(input logic [11:0] c, input logic we = 1'b0,
                     input logic [3:0] wa = 4'h0, input logic [7:0] wd = 8'h00);
    @(negedge clk);
    ctrl = c; prog_we = we; prog_addr = wa; prog_data = wd;
    #1;
    bus_seen = bus;
    chk("bus", bus, model_bus(c));
    @(posedge clk);
    model_step(c, we, wa, wd);
    #1;
    prog_we = 1'b0;
    chk("a_out", a_out, m_a);
    chk("opcode", opcode, m_ir / 16);
    chk("carry", carry, m_carry);
    chk("halted", halted, m_halt);
    chk("bus_conflict", bus_conflict, m_conf);
  endtask

  // Hold reset with every control bit set; outputs must stay zero.
  task automatic reset_hold(input int n, input logic we = 1'b0,
                            input logic [3:0] wa = 4'h0, input logic [7:0] wd = 8'h00);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; ctrl = 12'hFFF; prog_we = we; prog_addr = wa; prog_data = wd;
      model_reset();
      @(posedge clk);
      if (we) m_mem[wa] = wd;
      #1;
      prog_we = 1'b0;
      chk("rst_a", a_out, 0);
      chk("rst_op", opcode, 0);
      chk("rst_carry", carry, 0);
      chk("rst_halted", halted, 0);
      chk("rst_conflict", bus_conflict, 0);
      chk("rst_bus", bus, 0);
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0; ctrl = 12'h000;
  endtask

  initial begin
    logic [11:0] rc;
    logic [11:0] en;
    rst = 1'b1; ctrl = 12'hFFF; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    model_reset();

    // Reset held across 16 cycles, with RAM filled through the program port meanwhile
    for (int i = 0; i < 16; i++) reset_hold(1, 1'b1, 4'(i), 8'(i * 17 + 3));
    release_rst();

    // PC wrap: 17 increments from reset leaves pc = 1
    for (int i = 0; i < 17; i++) cyc(12'h400);
    cyc(12'h200);
    chk("pc_wrap", bus_seen, 8'h01);

    // Overflow and borrow
    reset_hold(2); release_rst();
    cyc(12'h000, 1'b1, 4'h0, 8'hF0);
    cyc(12'h000, 1'b1, 4'h1, 8'h20);
    cyc(12'h090);
    cyc(12'h400);
    cyc(12'h300);
    cyc(12'h084);
    cyc(12'h011);
    chk("ovf_a", a_out, 8'h10);
    chk("ovf_carry", carry, 1'b1);
    cyc(12'h013);
    chk("borrow_a", a_out, 8'hF0);
    chk("borrow_carry", carry, 1'b1);

    // Bus conflict: A (0x55) wins over RAM (0xAA), flag sets and sticks
    reset_hold(2); release_rst();
    cyc(12'h000, 1'b1, 4'h0, 8'h55);
    cyc(12'h090);
    cyc(12'h000, 1'b1, 4'h0, 8'hAA);
    chk("conf_pre", bus_conflict, 1'b0);
    cyc(12'h088);
    chk("conf_bus", bus_seen, 8'h55);
    chk("conf_set", bus_conflict, 1'b1);
    for (int i = 0; i < 3; i++) cyc(12'h000);
    chk("conf_sticky", bus_conflict, 1'b1);

    // Same-cycle program write to ram[mar] while reading: old data on the bus
    cyc(12'h080, 1'b1, 4'h0, 8'h3C);
    chk("rw_old", bus_seen, 8'hAA);
    cyc(12'h080);
    chk("rw_new", bus_seen, 8'h3C);

    // Full program LDA 9 / ADD 10 / SUB 11 / HLT, controller stages emulated
    reset_hold(2); release_rst();
    cyc(12'h000, 1'b1, 4'h0, 8'h09);
    cyc(12'h000, 1'b1, 4'h1, 8'h1A);
    cyc(12'h000, 1'b1, 4'h2, 8'h2B);
    cyc(12'h000, 1'b1, 4'h3, 8'hF0);
    cyc(12'h000, 1'b1, 4'h9, 8'h1C);
    cyc(12'h000, 1'b1, 4'hA, 8'h0E);
    cyc(12'h000, 1'b1, 4'hB, 8'h05);
    add_vec(12'h300, 8'h00, 4'h0, 1'b0, 1'b0); add_vec(12'h400, 8'h00, 4'h0, 1'b0, 1'b0);
    add_vec(12'h0C0, 8'h00, 4'h0, 1'b0, 1'b0); add_vec(12'h120, 8'h00, 4'h0, 1'b0, 1'b0);
    add_vec(12'h090, 8'h1C, 4'h0, 1'b0, 1'b0); add_vec(12'h000, 8'h1C, 4'h0, 1'b0, 1'b0);
    add_vec(12'h300, 8'h1C, 4'h0, 1'b0, 1'b0); add_vec(12'h400, 8'h1C, 4'h0, 1'b0, 1'b0);
    add_vec(12'h0C0, 8'h1C, 4'h1, 1'b0, 1'b0); add_vec(12'h120, 8'h1C, 4'h1, 1'b0, 1'b0);
    add_vec(12'h084, 8'h1C, 4'h1, 1'b0, 1'b0); add_vec(12'h011, 8'h2A, 4'h1, 1'b0, 1'b0);
    add_vec(12'h300, 8'h2A, 4'h1, 1'b0, 1'b0); add_vec(12'h400, 8'h2A, 4'h1, 1'b0, 1'b0);
    add_vec(12'h0C0, 8'h2A, 4'h2, 1'b0, 1'b0); add_vec(12'h120, 8'h2A, 4'h2, 1'b0, 1'b0);
    add_vec(12'h084, 8'h2A, 4'h2, 1'b0, 1'b0); add_vec(12'h013, 8'h25, 4'h2, 1'b0, 1'b0);
    add_vec(12'h300, 8'h25, 4'h2, 1'b0, 1'b0); add_vec(12'h400, 8'h25, 4'h2, 1'b0, 1'b0);
    add_vec(12'h0C0, 8'h25, 4'hF, 1'b0, 1'b0); add_vec(12'h800, 8'h25, 4'hF, 1'b1, 1'b0);
    foreach (tbl[i]) begin
      cyc(tbl[i].c);
      chk($sformatf("prog%0d_a", i), a_out, tbl[i].a);
      chk($sformatf("prog%0d_op", i), opcode, tbl[i].op);
      chk($sformatf("prog%0d_halt", i), halted, tbl[i].h);
      chk($sformatf("prog%0d_carry", i), carry, tbl[i].cy);
    end
    cyc(12'h600);
    chk("halt_pc", bus_seen, 8'h04);

    // Halt freeze: loads ignored, program port and bus stay live
    cyc(12'h090);
    chk("halt_freeze_a", a_out, 8'h25);
    cyc(12'h000, 1'b1, 4'h3, 8'h66);
    cyc(12'h080);
    chk("halt_ram_live", bus_seen, 8'h66);

    // Asynchronous reset pulse away from the clock edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_halt_clr", halted, 1'b0);
    chk("async_a_clr", a_out, 8'h00);
    #1 rst = 1'b0;
    model_reset();
    cyc(12'h080);
    chk("ram_kept", bus_seen, 8'h09);

    // Randomized: single-driver words first, then unconstrained (no HLT)
    reset_hold(2); release_rst();
    for (int i = 0; i < 400; i++) begin
      if (i < 200) begin
        case ($urandom_range(0, 5))
          0: en = 12'h001;
          1: en = 12'h008;
          2: en = 12'h020;
          3: en = 12'h080;
          4: en = 12'h200;
          default: en = 12'h000;
        endcase
        rc = 12'($urandom) & 12'h556 | en;
      end else begin
        rc = 12'($urandom) & 12'h7FF;
      end
      cyc(rc, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Registered datapath of the SAP CPU. It sits directly downstream of the controller and consumes its 12-bit control word. It holds the program counter, memory address register, 16×8 RAM, instruction register, A and B registers and the adder/subtractor, all joined by one shared 8-bit bus. It returns the current opcode to the controller and exposes A, halt status and bus state for observation.

## Interface
- `DATA_W`, default 8: bus, RAM word and register width.
- `ADDR_W`, default 4: PC, MAR and RAM address width; RAM depth is 2^ADDR_W.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `ctrl`, in, 12: control word. Bit map: 11 HLT, 10 PC_INC, 9 PC_EN, 8 MEM_LOAD, 7 MEM_EN, 6 IR_LOAD, 5 IR_EN, 4 A_LOAD, 3 A_EN, 2 B_LOAD, 1 ADDER_SUB, 0 ADDER_EN.
- `prog_we`, in, 1: program-load write strobe.
- `prog_addr`, in, ADDR_W: program-load address.
- `prog_data`, in, DATA_W: program-load data.
- `opcode`, out, 4: equals `ir[7:4]`; feeds the controller.
- `a_out`, out, DATA_W: A register.
- `bus`, out, DATA_W: current bus value (combinational).
- `carry`, out, 1: flag written by the last adder write-back.
- `halted`, out, 1: sticky halt flag.
- `bus_conflict`, out, 1: sticky flag, set when more than one driver is enabled.

## Operation
- **Bus drivers.** Drivers, listed in priority order:
  - ADDER_EN: sum.
  - A_EN: a.
  - IR_EN: zero-extended `ir[3:0]`.
  - MEM_EN: `ram[mar]`.
  - PC_EN: zero-extended pc.
  - With no enable asserted, the bus is 0.
  - Two or more enables in the same cycle: the bus takes the highest-priority driver, and `bus_conflict` sets on the next rising edge.
- **Adder.**
  - ADDER_SUB=0: sum = a + b mod 2^DATA_W, and the carry source is the carry-out.
  - ADDER_SUB=1: sum = a − b as two's complement, and the carry source is the borrow (a < b unsigned).
- **Register loads on the rising edge.** Several loads may fire in the same cycle; each one samples the same bus value.
  - PC_INC: pc ← pc+1, wrapping from 2^ADDR_W−1 to 0.
  - MEM_LOAD: mar ← `bus[ADDR_W-1:0]`.
  - IR_LOAD: ir ← bus.
  - A_LOAD: a ← bus.
  - B_LOAD: b ← bus.
- **Carry flag.** `carry` updates only when A_LOAD and ADDER_EN are both asserted; otherwise it holds.
- **Halt.** HLT sets `halted` on the next rising edge. While `halted`=1, every load and PC_INC is ignored. The bus and RAM program port remain live. Only `rst` clears `halted`.
- **Program port.**
  - `prog_we` writes `ram[prog_addr]` ← `prog_data` on the rising edge, at any time, including during reset and while halted.
  - If a program write targets `mar` in the same cycle as a MEM_EN read, the read returns the old data.
- **Reset.**
  - Outputs and registers reset to 0: pc, mar, ir, a, b, carry, halted and bus_conflict. Hence `opcode`=0 and `a_out`=0.
  - RAM contents are not reset.
  - Asserting reset mid-instruction aborts it immediately; no partial load survives.

## Timing
- The controller changes `ctrl` on the falling edge, and the datapath samples it on the following rising edge. `ctrl` is therefore stable for half a cycle before sampling.
- RAM read is asynchronous: `ram[mar]` is visible on the bus in the same cycle MEM_EN is asserted.
- `opcode` is valid from the rising edge that performs IR_LOAD, so it is valid before the controller's next stage.
- An instruction takes 6 clocks, with A updated at the end of stage 4 (LDA) or stage 5 (ADD/SUB).
- The `halted` flag is visible one rising edge after the HLT stage.
- Latency from write to read-back through MEM_EN is 1 clock.

## Structure
- Package `sap_pkg` holds the following; the controller imports the same package:
  - the SIG_* bit-index constants;
  - the opcode constants OP_LDA=0, OP_ADD=1, OP_SUB=2, OP_HLT=15;
  - the default widths.
- Sub-module `sap_ram` holds the 2^ADDR_W × DATA_W array. It has a synchronous write port (the program port) and an asynchronous read port addressed by mar.
- Bus mux, adder and registers stay in `sap_datapath`.

## Test plan
- **Reset:** hold rst for 2 cycles with ctrl=0xFFF → all outputs 0, nothing loads, and `bus_conflict` stays 0 until rst is released.
- **Full program, with the controller attached:**
  - Load `ram[0..3]` = 0x09, 0x1A, 0x2B, 0xF0 and `ram[9..11]` = 0x1C, 0x0E, 0x05.
  - Required: `a_out` goes 0x1C → 0x2A → 0x25.
  - `carry`=0 after the ADD and 0 after the SUB.
  - `halted`=1 after the 4th instruction's stage 3.
  - pc=4 at halt.
- **Overflow and borrow:** a=0xF0, b=0x20.
  - ADD gives a=0x10, carry=1.
  - Then SUB with b=0x20 gives a=0xF0, carry=1.
- **PC wrap:** PC_INC for 17 cycles from reset → pc=1.
- **Bus conflict:** assert MEM_EN+A_EN with a=0x55 and `ram[mar]`=0xAA → bus=0x55, and `bus_conflict`=1 after the edge and stays set.
- **Halt freeze and reset:**
  - After halt, apply A_LOAD with MEM_EN → a is unchanged.
  - `prog_we` still updates RAM.
  - Pulsing rst mid-cycle clears `halted` asynchronously, while RAM keeps its data.
